// File: rtl/piston_ctrl_if.sv
// Signal bundle between the slot-chain / plant side and the piston controller.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level.
//
// Ports: ap/an are extend/retract commands, s0/s1 raw end-of-stroke sensors,
// clr_fault the fault acknowledge; the controller returns valve drives,
// debounced sensors a0/a1, busy, fault and fault_code.
interface piston_ctrl_if;
    logic       ap;
    logic       an;
    logic       s0;
    logic       s1;
    logic       clr_fault;
    logic       valve_ext;
    logic       valve_ret;
    logic       a0;
    logic       a1;
    logic       busy;
    logic       fault;
    logic [1:0] fault_code;

    // Master drives commands and raw sensors; slave is the controller.
    modport master (
        output ap, an, s0, s1, clr_fault,
        input  valve_ext, valve_ret, a0, a1, busy, fault, fault_code
    );

    modport slave (
        input  ap, an, s0, s1, clr_fault,
        output valve_ext, valve_ret, a0, a1, busy, fault, fault_code
    );
endinterface

// File: rtl/piston_ctrl.sv
// Pneumatic piston controller: sensor sync + debounce, stroke FSM, stroke timeout.
// Latency: valves follow a command one cycle later; sensor edge to a0/a1 is 2+DEB_CYCLES.
// Backpressure: none; commands are levels and are re-evaluated every cycle.
//
// Ports: clk, rst_ (synchronous, active-low); pif (slave) carries ap/an commands,
// raw s0/s1 sensors, clr_fault, and returns valve_ext/valve_ret, a0/a1, busy,
// fault and fault_code. Every output is a flop.
module piston_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic         clk,
    input  logic         rst_,
    piston_ctrl_if.slave pif
);

    localparam logic [3:0]  DEB_LAST = 4'(DEB_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_RET,
        ST_DEAD,
        ST_FAULT
    } state_t;

    localparam logic [1:0] CODE_SNS = 2'b00;
    localparam logic [1:0] CODE_EXT = 2'b01;
    localparam logic [1:0] CODE_RET = 2'b10;
    localparam logic [1:0] CODE_CMD = 2'b11;

    // ---------------- sensor synchronizer and debounce ----------------
    // Bit 0 is the retracted sensor (s0 -> a0), bit 1 the extended one.
    logic [1:0] raw;
    logic [1:0] meta;
    logic [1:0] sync;
    logic [1:0] deb;
    logic [3:0] deb_cnt [2];

    assign raw = {pif.s1, pif.s0};

    always_ff @(posedge clk) begin
        if (!rst_) begin
            meta       <= '0;
            sync       <= '0;
            deb        <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            for (int i = 0; i < 2; i++) begin
                // Any cycle of agreement restarts the qualification window.
                if (sync[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 4'd1;
                end
            end
        end
    end

    logic a0;
    logic a1;
    assign a0 = deb[0];
    assign a1 = deb[1];

    // ---------------- stroke FSM ----------------
    state_t      state;
    state_t      state_nxt;
    logic        dead_to_ret;      // direction to take when DEAD expires
    logic        dead_to_ret_nxt;
    logic [15:0] timer;
    logic [1:0]  code_q;
    logic [1:0]  code_nxt;
    logic        valve_ext_q;
    logic        valve_ret_q;
    logic        busy_q;
    logic        fault_q;

    logic cmd_conflict;
    logic sns_conflict;
    logic ext_req;
    logic ret_req;
    logic timed_out;

    assign cmd_conflict = pif.ap & pif.an;
    assign sns_conflict = a0 & a1;
    assign ext_req      = pif.ap & ~pif.an;
    assign ret_req      = pif.an & ~pif.ap;
    assign timed_out    = (timer >= TMO_LAST);

    always_comb begin
        state_nxt       = state;
        dead_to_ret_nxt = dead_to_ret;
        code_nxt        = code_q;

        if (state != ST_FAULT && cmd_conflict) begin
            state_nxt = ST_FAULT;
            code_nxt  = CODE_CMD;
        end else if (state != ST_FAULT && sns_conflict) begin
            state_nxt = ST_FAULT;
            code_nxt  = CODE_SNS;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A command toward the end already reached is ignored.
                    if (ext_req && !a1) begin
                        state_nxt = ST_EXT;
                    end else if (ret_req && !a0) begin
                        state_nxt = ST_RET;
                    end
                end
                ST_EXT: begin
                    // Arrival is checked before the timer so a sensor landing
                    // on the last allowed cycle counts as completion.
                    if (a1) begin
                        state_nxt = ST_IDLE;
                    end else if (ret_req) begin
                        state_nxt       = ST_DEAD;
                        dead_to_ret_nxt = 1'b1;
                    end else if (timed_out) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = CODE_EXT;
                    end
                end
                ST_RET: begin
                    if (a0) begin
                        state_nxt = ST_IDLE;
                    end else if (ext_req) begin
                        state_nxt       = ST_DEAD;
                        dead_to_ret_nxt = 1'b0;
                    end else if (timed_out) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = CODE_RET;
                    end
                end
                ST_DEAD: begin
                    state_nxt = dead_to_ret ? ST_RET : ST_EXT;
                end
                ST_FAULT: begin
                    if (pif.clr_fault && !pif.ap && !pif.an) begin
                        state_nxt = ST_IDLE;
                        code_nxt  = CODE_SNS;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state       <= ST_IDLE;
            dead_to_ret <= 1'b0;
            timer       <= '0;
            code_q      <= '0;
            valve_ext_q <= 1'b0;
            valve_ret_q <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            dead_to_ret <= dead_to_ret_nxt;

            // Timer restarts on every stroke entry (including after DEAD)
            // and sits at zero outside stroke states.
            if ((state_nxt == ST_EXT || state_nxt == ST_RET) && state_nxt == state) begin
                if (timer != 16'hFFFF) begin
                    timer <= timer + 16'd1;
                end
            end else begin
                timer <= '0;
            end

            // Outputs are decoded from the next state so they line up with it.
            valve_ext_q <= (state_nxt == ST_EXT);
            valve_ret_q <= (state_nxt == ST_RET);
            busy_q      <= (state_nxt == ST_EXT) || (state_nxt == ST_RET) || (state_nxt == ST_DEAD);
            fault_q     <= (state_nxt == ST_FAULT);
            code_q      <= (state_nxt == ST_FAULT) ? code_nxt : 2'b00;
        end
    end

    assign pif.valve_ext  = valve_ext_q;
    assign pif.valve_ret  = valve_ret_q;
    assign pif.a0         = a0;
    assign pif.a1         = a1;
    assign pif.busy       = busy_q;
    assign pif.fault      = fault_q;
    assign pif.fault_code = code_q;

endmodule

// File: tb/tb_piston_ctrl.sv
// Testbench for piston_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the controller.
module tb_piston_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 120;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    piston_ctrl_if pif ();

    piston_ctrl #(
        .DEB_CYCLES (DEB),
        .TIMEOUT    (TMO)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .pif  (pif.slave)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural reference ----------------
    typedef enum int {M_IDLE, M_EXT, M_RET, M_DEAD, M_FAULT} mode_t;
    mode_t    m_mode;
    bit       m_goes_ret;
    int       m_elapsed;     // full cycles spent in the current stroke
    bit       m_a0;
    bit       m_a1;
    bit [1:0] m_code;
    bit       h0[$];         // raw samples per edge, newest first
    bit       h1[$];

    task automatic model_reset();
        m_mode = M_IDLE; m_goes_ret = 0; m_elapsed = 0;
        m_a0 = 0; m_a1 = 0; m_code = 0;
        h0 = {}; h1 = {};
        for (int i = 0; i < DEB + 2; i++) begin
            h0.push_back(1'b0);
            h1.push_back(1'b0);
        end
    endtask

    // A debounced level flips when the sensor, seen two edges late, disagreed
    // with it at each of the last DEB edges.
    function automatic bit flips(input bit h[$], input bit cur);
        for (int i = 2; i < DEB + 2; i++) begin
            if (h[i] == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit ap, input bit an,
                              input bit s0, input bit s1, input bit clr);
        bit a0_old, a1_old;
        if (!r) begin
            model_reset();
            return;
        end
        a0_old = m_a0;
        a1_old = m_a1;
        if (m_mode != M_FAULT && ap && an) begin
            m_mode = M_FAULT; m_code = 2'b11;
        end else if (m_mode != M_FAULT && a0_old && a1_old) begin
            m_mode = M_FAULT; m_code = 2'b00;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (ap && !an && !a1_old) begin m_mode = M_EXT; m_elapsed = 0; end
                    else if (an && !ap && !a0_old) begin m_mode = M_RET; m_elapsed = 0; end
                end
                M_EXT: begin
                    m_elapsed++;
                    if (a1_old) m_mode = M_IDLE;
                    else if (an && !ap) begin m_mode = M_DEAD; m_goes_ret = 1; end
                    else if (m_elapsed >= TMO) begin m_mode = M_FAULT; m_code = 2'b01; end
                end
                M_RET: begin
                    m_elapsed++;
                    if (a0_old) m_mode = M_IDLE;
                    else if (ap && !an) begin m_mode = M_DEAD; m_goes_ret = 0; end
                    else if (m_elapsed >= TMO) begin m_mode = M_FAULT; m_code = 2'b10; end
                end
                M_DEAD: begin
                    m_mode = m_goes_ret ? M_RET : M_EXT;
                    m_elapsed = 0;
                end
                default: begin
                    if (clr && !ap && !an) begin m_mode = M_IDLE; m_code = 0; end
                end
            endcase
        end
        h0.push_front(s0); void'(h0.pop_back());
        h1.push_front(s1); void'(h1.pop_back());
        if (flips(h0, m_a0)) m_a0 = ~m_a0;
        if (flips(h1, m_a1)) m_a1 = ~m_a1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_model();
        check("m_valve_ext", pif.valve_ext, m_mode == M_EXT);
        check("m_valve_ret", pif.valve_ret, m_mode == M_RET);
        check("m_busy", pif.busy, m_mode == M_EXT || m_mode == M_RET || m_mode == M_DEAD);
        check("m_fault", pif.fault, m_mode == M_FAULT);
        check("m_fault_code", pif.fault_code, (m_mode == M_FAULT) ? m_code : 2'b00);
        check("m_a0", pif.a0, m_a0);
        check("m_a1", pif.a1, m_a1);
    endtask

    function automatic logic [7:0] outs();
        return {pif.valve_ext, pif.valve_ret, pif.a0, pif.a1, pif.busy, pif.fault, pif.fault_code};
    endfunction

    // One clock: inputs held across the edge, outputs sampled 1 time unit later.
    task automatic tick();
        bit r, ap, an, s0, s1, clr;
        r = rst_; ap = pif.ap; an = pif.an; s0 = pif.s0; s1 = pif.s1; clr = pif.clr_fault;
        @(posedge clk);
        #1;
        model_step(r, ap, an, s0, s1, clr);
        cmp_model();
    endtask

    // Cycles until a selected output goes high (0:a0 1:a1 2:fault); -1 if never.
    task automatic wait_high(input int sel, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((sel == 0 && pif.a0) || (sel == 1 && pif.a1) || (sel == 2 && pif.fault)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        model_reset();
        rst_ = 1'b0;
        pif.ap = 0; pif.an = 0; pif.s0 = 0; pif.s1 = 0; pif.clr_fault = 0;
        tick(); tick();
        check("reset_outs", outs(), 8'h00);

        // retracted sensor settles; extend command
        rst_ = 1'b1;
        pif.s0 = 1;
        wait_high(0, 30, n);
        check("a0_latency", n, 6);
        pif.ap = 1; pif.s0 = 0;
        tick();
        check("ext_start", {pif.valve_ext, pif.valve_ret, pif.busy}, 3'b101);
        pif.ap = 0;

        // extend stroke of about 100 cycles
        seen = 0;
        for (int i = 0; i < 99; i++) begin tick(); seen |= pif.fault; end
        pif.s1 = 1;
        wait_high(1, 30, n);
        check("a1_latency", n, 6);
        check("ext_hold", pif.valve_ext, 1'b1);
        tick();
        check("ext_done", {pif.valve_ext, pif.busy}, 2'b00);
        check("ext_no_fault", seen | pif.fault, 1'b0);

        // retract stroke
        pif.an = 1; pif.s1 = 0;
        tick();
        check("ret_start", {pif.valve_ext, pif.valve_ret}, 2'b01);
        pif.an = 0;
        repeat (20) tick();
        pif.s0 = 1;
        wait_high(0, 30, n);
        check("ret_a0_latency", n, 6);
        tick();
        check("ret_done", pif.valve_ret, 1'b0);

        // 3-cycle glitch on s1 is rejected
        pif.s1 = 1;
        repeat (3) tick();
        pif.s1 = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin tick(); seen |= pif.a1; end
        check("glitch_a1", seen, 1'b0);

        // extend timeout with s1 never arriving
        pif.ap = 1; pif.s0 = 0;
        tick();
        check("tmo_valve_on", pif.valve_ext, 1'b1);
        wait_high(2, TMO + 20, n);
        check("tmo_cycles", n, TMO);
        check("tmo_code", pif.fault_code, 2'b01);
        check("tmo_valves", {pif.valve_ext, pif.valve_ret, pif.busy}, 3'b000);
        pif.clr_fault = 1;
        tick();
        check("clr_blocked", pif.fault, 1'b1);
        pif.ap = 0;
        tick();
        check("clr_ok", {pif.fault, pif.fault_code}, 3'b000);
        pif.clr_fault = 0;

        // reversal through DEAD, then command conflict
        pif.ap = 1;
        tick();
        check("rev_ext", pif.valve_ext, 1'b1);
        repeat (5) tick();
        pif.ap = 0; pif.an = 1;
        tick();
        check("rev_dead", {pif.valve_ext, pif.valve_ret, pif.busy}, 3'b001);
        tick();
        check("rev_ret", {pif.valve_ext, pif.valve_ret}, 2'b01);
        pif.ap = 1;
        tick();
        check("cmd_conflict", {pif.fault, pif.fault_code}, 3'b111);
        pif.ap = 0; pif.an = 0; pif.clr_fault = 1;
        tick();
        pif.clr_fault = 0;
        check("cmd_clear", pif.fault, 1'b0);

        // sensor arrives on the very cycle the timer expires
        pif.ap = 1;
        tick();
        repeat (TMO - 7) tick();
        pif.s1 = 1;
        repeat (6) tick();
        check("race_pre", {pif.a1, pif.valve_ext}, 2'b11);
        tick();
        check("race_sensor_wins", {pif.fault, pif.valve_ext, pif.busy}, 3'b000);
        pif.ap = 0;

        // reset mid-retract
        pif.an = 1; pif.s1 = 0;
        tick();
        check("rst_ret_on", pif.valve_ret, 1'b1);
        repeat (3) tick();
        rst_ = 0;
        tick();
        check("rst_drop", outs(), 8'h00);
        for (int i = 0; i < 3; i++) begin tick(); check("rst_hold", outs(), 8'h00); end
        pif.an = 0;
        rst_ = 1;

        // both end sensors active
        pif.s0 = 1; pif.s1 = 1;
        repeat (7) tick();
        check("sns_conflict", {pif.fault, pif.fault_code}, 3'b100);
        pif.s0 = 0; pif.s1 = 0; pif.clr_fault = 1;
        repeat (10) tick();
        check("sns_clear", pif.fault, 1'b0);
        pif.clr_fault = 0;

        // random traffic against the model
        for (int c = 0; c < 2500; c++) begin
            rst_ = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) begin
                int k;
                k = $urandom_range(0, 99);
                pif.ap = (k >= 40 && k < 70) || k >= 97;
                pif.an = (k >= 70);
            end
            if ($urandom_range(0, 29) == 0) pif.s0 = ~pif.s0;
            if ($urandom_range(0, 29) == 0) pif.s1 = ~pif.s1;
            pif.clr_fault = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
